// File: rtl/reg_router_pkg.sv
// reg_router_pkg: shared FSM states, error word and address-decode constants for the WB register router
package reg_router_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DRAIN} state_t;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int SEL_LSB = 11;
  localparam int SEL_MSB = 12;
  localparam int TGT_COMMS = 0;
  localparam int TGT_PINMUX = 1;
  localparam int TGT_SPARE = 2;
endpackage

// File: rtl/reg_router_tmo.sv
// reg_router_tmo: access timeout counter, expires on the TMO_CYC-th enabled cycle after a clear
module reg_router_tmo
  import reg_router_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt;
  // count cycles spent waiting on a target; clear restarts the window
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = en && (cnt == CW'(TMO_CYC - 1));
endmodule

// File: rtl/wbs_reg_router.sv
// wbs_reg_router: WB slave front end routing one transaction to a register target; timeout under REG_ROUTER_TIMEOUT_EN
module wbs_reg_router
  import reg_router_pkg::*;
#(
  parameter int WB_WIDTH = 32,
  parameter int N_TGT = 3,
  parameter int TGT_ADDR_W = 11,
  parameter int TMO_CYC = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [WB_WIDTH-1:0]   wbs_adr_i,
  input  logic [WB_WIDTH-1:0]   wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [WB_WIDTH-1:0]   wbs_dat_o,
  output logic [N_TGT-1:0]      reg_cs,
  output logic                  reg_wr,
  output logic [TGT_ADDR_W-1:0] reg_addr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_be,
  input  logic [N_TGT*32-1:0]   reg_rdata,
  input  logic [N_TGT-1:0]      reg_ack,
  output logic                  err_flag,
  input  logic                  err_clr
);
  localparam logic [2:0] NT = 3'(N_TGT);
  state_t state;
  logic [1:0] sel, sel_q;
  logic req, mapped, tgt_ack, tmo_exp;
  logic [31:0] rd_sel;
  assign sel = wbs_adr_i[SEL_MSB:SEL_LSB];
  assign mapped = {1'b0, sel} < NT;
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign tgt_ack = reg_ack[sel_q];
  assign rd_sel = reg_rdata[32*sel_q +: 32];
`ifdef REG_ROUTER_TIMEOUT_EN
  logic tmo_clr, tmo_en;
  assign tmo_clr = (state == IDLE && req && mapped) || (state == ACCESS && !wbs_cyc_i);
  assign tmo_en = (state == ACCESS) || (state == DRAIN);
  reg_router_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .clr(tmo_clr),
    .en(tmo_en),
    .expire(tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif
  // transaction sequencer: decode, chip-select handshake, single ack back to the host
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= IDLE;
      reg_cs <= '0;
      wbs_ack_o <= 1'b0;
      reg_wr <= 1'b0;
      wbs_dat_o <= '0;
      reg_addr <= '0;
      reg_wdata <= '0;
      reg_be <= '0;
      sel_q <= '0;
      err_flag <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      if (err_clr) err_flag <= 1'b0;
      case (state)
        IDLE:
          if (req && mapped) begin
            reg_wr <= wbs_we_i;
            reg_addr <= wbs_adr_i[TGT_ADDR_W-1:0];
            reg_wdata <= wbs_dat_i[31:0];
            reg_be <= wbs_sel_i;
            sel_q <= sel;
            reg_cs <= N_TGT'(1) << sel;
            state <= ACCESS;
          end else if (req) begin
            wbs_dat_o <= WB_WIDTH'(ERR_DATA);
            err_flag <= 1'b1;
            state <= RESP;
          end
        ACCESS:
          if (tgt_ack || tmo_exp) begin
            reg_cs <= '0;
            wbs_dat_o <= tgt_ack ? (reg_wr ? '0 : WB_WIDTH'(rd_sel)) : WB_WIDTH'(ERR_DATA);
            if (!tgt_ack) err_flag <= 1'b1;
            state <= wbs_cyc_i ? RESP : IDLE;
          end else if (!wbs_cyc_i) state <= DRAIN;
        DRAIN:
          if (tgt_ack || tmo_exp) begin
            reg_cs <= '0;
            if (!tgt_ack) err_flag <= 1'b1;
            state <= IDLE;
          end
        RESP: begin
          wbs_ack_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wbs_reg_router.sv
// tb_wbs_reg_router: directed stimulus with an ack-data scoreboard for wbs_reg_router
module tb_wbs_reg_router;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0, err_clr = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic ack, wr, err;
  logic [31:0] dout, wdata;
  logic [2:0] cs;
  logic [10:0] addr;
  logic [3:0] be;
  logic [95:0] rdata = 0;
  logic [2:0] rack = 0;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  wbs_reg_router #(.WB_WIDTH(32), .N_TGT(3), .TGT_ADDR_W(11), .TMO_CYC(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dout),
    .reg_cs(cs), .reg_wr(wr), .reg_addr(addr), .reg_wdata(wdata), .reg_be(be),
    .reg_rdata(rdata), .reg_ack(rack), .err_flag(err), .err_clr(err_clr)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    adr = a; we = w; dat = d; sel = s; cyc = 1; stb = 1;
  endtask
  task automatic wait_ack(input string name);
    logic got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = ack;
    end
    chk(name, 32'(got), 32'd1);
    cyc = 0; stb = 0;
  endtask
  // scoreboard monitor: every host ack must match the next expected read word
  initial forever begin
    @(negedge clk);
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack with data %h expected no ack", dout);
      end else chk("ack_data", dout, exp_q.pop_front());
    end
  end
  initial begin
    rdata = {32'hCAFE_0002, 32'h1234_5678, 32'h0BAD_0000};
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_cs", 32'(cs), 0);
    chk("rst_dat", dout, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(addr), 0);
    rst = 0;
    exp_q.push_back(32'h1234_5678);
    req(32'h0000_0810, 0, 0, 4'hF);
    @(negedge clk);
    chk("rd_cs", 32'(cs), 32'h2);
    chk("rd_addr", 32'(addr), 32'h010);
    chk("rd_wr", 32'(wr), 0);
    @(negedge clk);
    @(negedge clk);
    rack = 3'b010;
    @(negedge clk);
    rack = 0;
    chk("rd_cs_drop", 32'(cs), 0);
    wait_ack("rd_ack");
    exp_q.push_back(32'h0);
    req(32'h0000_0004, 1, 32'hA5A5_0001, 4'b0011);
    @(negedge clk);
    chk("wr_cs", 32'(cs), 32'h1);
    chk("wr_wr", 32'(wr), 1);
    chk("wr_be", 32'(be), 32'h3);
    chk("wr_wdata", wdata, 32'hA5A5_0001);
    chk("wr_addr", 32'(addr), 32'h004);
    rack = 3'b001;
    @(negedge clk);
    rack = 0;
    wait_ack("wr_ack");
    exp_q.push_back(32'hDEAD_BEEF);
    req(32'h0000_1800, 0, 0, 4'hF);
    @(negedge clk);
    chk("unm_cs", 32'(cs), 0);
    chk("unm_ack_c1", 32'(ack), 0);
    @(negedge clk);
    chk("unm_ack_c2", 32'(ack), 1);
    chk("unm_err", 32'(err), 1);
    cyc = 0; stb = 0;
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_clr", 32'(err), 0);
    exp_q.push_back(32'hCAFE_0002);
    req(32'h0000_17FC, 0, 0, 4'hF);
    @(negedge clk);
    chk("spare_cs", 32'(cs), 32'h4);
    chk("spare_addr", 32'(addr), 32'h7FC);
    rack = 3'b011;
    @(negedge clk);
    chk("ign_ack_cs", 32'(cs), 32'h4);
    rack = 3'b100;
    @(negedge clk);
    rack = 0;
    wait_ack("spare_ack");
    exp_q.push_back(32'hDEAD_BEEF);
    req(32'h0000_1800, 0, 0, 4'hF);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("set_wins", 32'(err), 1);
    wait_ack("sw_ack");
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_clr2", 32'(err), 0);
    req(32'h0000_0000, 0, 0, 4'hF);
    @(negedge clk);
    chk("abort_cs", 32'(cs), 32'h1);
    cyc = 0; stb = 0;
    repeat (4) @(negedge clk);
    chk("abort_hold", 32'(cs), 32'h1);
    @(negedge clk);
    rack = 3'b001;
    @(negedge clk);
    rack = 0;
    chk("abort_cs_drop", 32'(cs), 0);
    chk("abort_no_ack", 32'(ack), 0);
    exp_q.push_back(32'h0);
    req(32'h0000_0820, 1, 32'h0000_0055, 4'hF);
    @(negedge clk);
    chk("post_abort_cs", 32'(cs), 32'h2);
    rack = 3'b010;
    @(negedge clk);
    rack = 0;
    wait_ack("post_abort_ack");
    req(32'h0000_0000, 0, 0, 4'hF);
    @(negedge clk);
    chk("rst_mid_cs_pre", 32'(cs), 32'h1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_cs", 32'(cs), 0);
    chk("rst_mid_ack", 32'(ack), 0);
    chk("rst_mid_dat", dout, 0);
    rst = 0; cyc = 0; stb = 0;
    rack = 3'b001;
    @(negedge clk);
    chk("stray_cs", 32'(cs), 0);
    rack = 0;
    repeat (3) @(negedge clk);
`ifdef REG_ROUTER_TIMEOUT_EN
    begin
      int n = 0;
      exp_q.push_back(32'hDEAD_BEEF);
      req(32'h0000_0800, 0, 0, 4'hF);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (cs != 3'b010) break;
        n++;
      end
      chk("tmo_cs_cycles", n, 8);
      wait_ack("tmo_ack");
      chk("tmo_err", 32'(err), 1);
    end
`endif
    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
